val2_shift_sequencer: RTL

//  Multi-cycle controller that produces the execute-stage second operand (val2) and shifter carry-out.

---
 rtl/val2_pkg.sv | 25 ++
 rtl/shift_step.sv | 49 ++++
 rtl/val2_shift_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/val2_pkg.sv
// ---------------------------------------------------------------------------
// val2_pkg: shared shift encodings, FSM states and limits. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package val2_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    localparam int MAX_AMT = 33;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step: combinational shift of {data, carry} by 0..STEP positions. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_step
    import val2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             carry_i,
    input  shift_t           type_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] data_o,
    output logic             carry_o
);

    logic [WIDTH:0]   w_lsl;
    logic [WIDTH:0]   w_lsr;
    logic [WIDTH:0]   w_asr;
    logic [WIDTH-1:0] w_ror;

    // A guard bit on each side of the data catches the last bit shifted out.
    always_comb begin
        w_lsl   = {1'b0, data_i} << k_i;
        w_lsr   = {data_i, 1'b0} >> k_i;
        w_asr   = $signed({data_i, 1'b0}) >>> k_i;
        w_ror   = (data_i >> k_i) | (data_i << (WIDTH - int'(k_i)));
        data_o  = data_i;
        carry_o = carry_i;
        if (k_i != '0) begin
            case (type_i)
                SH_LSL:  {carry_o, data_o} = w_lsl;
                SH_LSR:  {data_o, carry_o} = w_lsr;
                SH_ASR:  {data_o, carry_o} = w_asr;
                default: begin
                    data_o  = w_ror;
                    carry_o = w_ror[WIDTH-1];
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/val2_shift_sequencer.sv
// ---------------------------------------------------------------------------
// val2_shift_sequencer: multi-cycle generator of ALU operand 2 and shifter carry. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module val2_shift_sequencer
    import val2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             is_memory_ins,
    input  logic             imm,
    input  logic             reg_shift,
    input  logic [11:0]      shift_operand,
    input  logic [WIDTH-1:0] val_rm,
    input  logic [7:0]       val_rs,
    input  logic             carry_in,
    output logic [WIDTH-1:0] val2,
    output logic             carry_out,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int KW = $clog2(STEP + 1);

    state_t           state_q;
    logic             mem_q, imm_q, rsh_q, cin_q;
    logic [11:0]      shop_q;
    logic [WIDTH-1:0] rm_q;
    logic [7:0]       rs_q;
    logic [WIDTH-1:0] data_q, val2_q;
    logic             carry_q, carry_out_q, busy_q, done_q;
    logic [5:0]       rem_q;

    shift_t           ld_type_d;
    logic [WIDTH-1:0] ld_data_d, sp_val_d, fin_val_d;
    logic [5:0]       ld_amt_d, rem_d;
    logic             ld_special_d, sp_carry_d, ld_finish_d, fin_carry_d;
    logic [KW-1:0]    k_d;
    logic [WIDTH-1:0] step_data_d;
    logic             step_carry_d;

    // Decode of the latched operands: effective amount, shift type and the
    // single-cycle results (memory offset, RRX, ROR by a multiple of 32).
    always_comb begin
        ld_type_d    = shift_t'(shop_q[6:5]);
        ld_data_d    = rm_q;
        ld_amt_d     = '0;
        ld_special_d = 1'b0;
        sp_val_d     = rm_q;
        sp_carry_d   = cin_q;
        if (mem_q) begin
            ld_special_d = 1'b1;
            sp_val_d     = {{(WIDTH-12){1'b0}}, shop_q};
        end else if (imm_q) begin
            ld_type_d = SH_ROR;
            ld_data_d = {{(WIDTH-8){1'b0}}, shop_q[7:0]};
            ld_amt_d  = {1'b0, shop_q[11:8], 1'b0};
        end else if (rsh_q) begin
            case (ld_type_d)
                SH_LSL, SH_LSR: ld_amt_d = (rs_q > 8'(MAX_AMT)) ? 6'(MAX_AMT) : rs_q[5:0];
                SH_ASR:         ld_amt_d = (rs_q > 8'd32) ? 6'd32 : rs_q[5:0];
                default: begin
                    ld_amt_d = {1'b0, rs_q[4:0]};
                    if (rs_q[4:0] == 5'd0 && rs_q != 8'd0) begin
                        ld_special_d = 1'b1;
                        sp_carry_d   = rm_q[WIDTH-1];
                    end
                end
            endcase
        end else begin
            case (ld_type_d)
                SH_LSL:         ld_amt_d = {1'b0, shop_q[11:7]};
                SH_LSR, SH_ASR: ld_amt_d = (shop_q[11:7] == 5'd0) ? 6'd32 : {1'b0, shop_q[11:7]};
                default: begin
                    if (shop_q[11:7] == 5'd0) begin
                        ld_special_d = 1'b1;
                        sp_val_d     = {cin_q, rm_q[WIDTH-1:1]};
                        sp_carry_d   = rm_q[0];
                    end else begin
                        ld_amt_d = {1'b0, shop_q[11:7]};
                    end
                end
            endcase
        end
        ld_finish_d = ld_special_d || (ld_amt_d == 6'd0);
        fin_val_d   = ld_special_d ? sp_val_d : ld_data_d;
        fin_carry_d = ld_special_d ? sp_carry_d : cin_q;
    end

    assign k_d   = (rem_q < 6'(STEP)) ? rem_q[KW-1:0] : KW'(STEP);
    assign rem_d = rem_q - 6'(k_d);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data_i  (data_q),
        .carry_i (carry_q),
        .type_i  (ld_type_d),
        .k_i     (k_d),
        .data_o  (step_data_d),
        .carry_o (step_carry_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_q       <= 1'b0;
            imm_q       <= 1'b0;
            rsh_q       <= 1'b0;
            cin_q       <= 1'b0;
            shop_q      <= '0;
            rm_q        <= '0;
            rs_q        <= '0;
            data_q      <= '0;
            carry_q     <= 1'b0;
            rem_q       <= '0;
            val2_q      <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        mem_q   <= is_memory_ins;
                        imm_q   <= imm;
                        rsh_q   <= reg_shift;
                        cin_q   <= carry_in;
                        shop_q  <= shift_operand;
                        rm_q    <= val_rm;
                        rs_q    <= val_rs;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (ld_finish_d) begin
                        val2_q      <= fin_val_d;
                        carry_out_q <= fin_carry_d;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        data_q  <= ld_data_d;
                        carry_q <= cin_q;
                        rem_q   <= ld_amt_d;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    data_q  <= step_data_d;
                    carry_q <= step_carry_d;
                    rem_q   <= rem_d;
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (rem_d == 6'd0) begin
                        val2_q      <= step_data_d;
                        carry_out_q <= step_carry_d;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign val2      = val2_q;
    assign carry_out = carry_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign stall     = start | busy_q;

endmodule

`default_nettype wire
